// File: rtl/dcache_line_mem_adapter.sv
// rtl/dcache_line_mem_adapter.sv - data-cache line to 32-bit word-bus adapter (option: DCACHE_CRITICAL_WORD_FIRST_EN)
//
// Takes one cache-line refill or writeback, runs it as BEATS single-word
// transfers on a req/ack memory bus and answers the cache with a single ack.
// With DCACHE_CRITICAL_WORD_FIRST_EN defined, refills begin at the requested
// word and wrap around the line; writebacks always begin at word 0.

module dcache_line_mem_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // cache line side
  input  logic                    dcache2mem_req_i,
  input  logic                    dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0]   dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0]   dcache2mem_data_i,
  output logic                    mem2dcache_ack_o,
  output logic [LINE_WIDTH-1:0]   mem2dcache_data_o,
  // word bus side
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [WORD_WIDTH-1:0]   mem_wdata_o,
  output logic [WORD_WIDTH/8-1:0] mem_sel_byte_o,
  input  logic                    mem_ack_i,
  input  logic [WORD_WIDTH-1:0]   mem_rdata_i
);

  localparam int BEATS      = LINE_WIDTH / WORD_WIDTH;
  localparam int IDX_W      = $clog2(BEATS);
  localparam int OFF_W      = $clog2(WORD_WIDTH / 8);
  localparam int LINE_OFF_W = IDX_W + OFF_W;
  localparam int HI_W       = ADDR_WIDTH - LINE_OFF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_wr;
  logic [HI_W-1:0]       r_addr_hi;
  logic [LINE_WIDTH-1:0] r_wdata_buf;
  logic [LINE_WIDTH-1:0] r_line_buf;
  logic [IDX_W-1:0]      r_beat_cnt;
  logic [IDX_W-1:0]      r_start;

  logic                  w_accept;
  logic                  w_beat_done;
  logic                  w_last_beat;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_start;
  logic                  w_unused_addr;

  // Word offset within the line is only meaningful for critical-word-first refills.
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign w_start = dcache2mem_wr_i ? '0 : dcache2mem_addr_i[LINE_OFF_W-1:OFF_W];
`else
  assign w_start = '0;
`endif

  // Low address bits never reach the word bus directly; they are rebuilt from w_idx.
  assign w_unused_addr = ^dcache2mem_addr_i[LINE_OFF_W-1:0];

  // Beat order wraps around the line starting from the latched start index.
  assign w_idx       = r_start + r_beat_cnt;
  assign w_beat_done = (r_state == S_XFER) && mem_ack_i;
  assign w_last_beat = (r_beat_cnt == IDX_W'(BEATS - 1));

  // Whole words only, so every byte lane is always enabled.
  assign mem_sel_byte_o = '1;

  // The assembled refill line doubles as the response data and persists across writebacks.
  assign mem2dcache_data_o = r_line_buf;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus outputs; bus signals are driven only while a word transfer is active.
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem2dcache_ack_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dcache2mem_req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        mem_req_o   = 1'b1;
        mem_we_o    = r_wr;
        mem_addr_o  = {r_addr_hi, w_idx, {OFF_W{1'b0}}};
        mem_wdata_o = r_wdata_buf[w_idx*WORD_WIDTH +: WORD_WIDTH];
        if (mem_ack_i && w_last_beat) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        mem2dcache_ack_o = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture, beat counting and refill line assembly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr        <= 1'b0;
      r_addr_hi   <= '0;
      r_wdata_buf <= '0;
      r_line_buf  <= '0;
      r_beat_cnt  <= '0;
      r_start     <= '0;
    end else begin
      if (w_accept) begin
        r_wr        <= dcache2mem_wr_i;
        r_addr_hi   <= dcache2mem_addr_i[ADDR_WIDTH-1:LINE_OFF_W];
        r_wdata_buf <= dcache2mem_data_i;
        r_start     <= w_start;
        r_beat_cnt  <= '0;
      end
      if (w_beat_done) begin
        r_beat_cnt <= r_beat_cnt + IDX_W'(1);
        if (!r_wr) begin
          r_line_buf[w_idx*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_line_mem_adapter.sv
// tb/tb_dcache_line_mem_adapter.sv - self-checking bench for dcache_line_mem_adapter

module tb_dcache_line_mem_adapter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic         mem2dcache_ack_o;
  logic [127:0] mem2dcache_data_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic [3:0]   mem_sel_byte_o;
  logic         mem_ack_i;
  logic [31:0]  mem_rdata_i;

  dcache_line_mem_adapter dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .dcache2mem_req_i  (req),
    .dcache2mem_wr_i   (wr),
    .dcache2mem_addr_i (addr),
    .dcache2mem_data_i (wdata),
    .mem2dcache_ack_o  (mem2dcache_ack_o),
    .mem2dcache_data_o (mem2dcache_data_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_sel_byte_o    (mem_sel_byte_o),
    .mem_ack_i         (mem_ack_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [31:0]  base;
    int           w;
    logic [127:0] exp_data;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } resp_t;

  beat_t        beat_q[$];
  resp_t        resp_q[$];
  vec_t         tab[5];

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_resp = 0;
  int           cyc = 0;
  int           wait_cnt = 0;
  int           wait_tab[4] = '{0, 0, 0, 0};
  logic [1:0]   beat_no = 2'd0;
  logic [31:0]  rd_base = 32'h0;
  logic [127:0] last_line = '0;

  // memory model: wait_tab[beat] wait cycles before each ack, word k returns base|k
  assign mem_ack_i   = mem_req_o && (wait_cnt >= wait_tab[beat_no]);
  assign mem_rdata_i = rd_base | {30'd0, mem_addr_o[3:2]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n || mem2dcache_ack_o) beat_no <= 2'd0;
    else if (mem_req_o && mem_ack_i) beat_no <= 2'(beat_no + 2'd1);
    if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] base);
    return {base | 32'd3, base | 32'd2, base | 32'd1, base};
  endfunction

  task automatic check_beat(input string nm, input beat_t b);
    check(nm, 128'({mem_addr_o, mem_we_o, (mem_we_o ? mem_wdata_o : 32'h0), mem_sel_byte_o}),
              128'({b.addr, b.we, (b.we ? b.wdata : 32'h0), 4'hF}));
  endtask

  task automatic run_monitor();
    resp_t r;
    beat_t b;
    forever begin
      @(negedge clk);
      if (mem_req_o && mem_ack_i) begin
        check("beat_pending", 128'(beat_q.size() > 0), 128'(1));
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          check_beat("beat", b);
        end
      end else if (mem_req_o && beat_q.size() > 0) begin
        check_beat("stall_hold", beat_q[0]);
      end
      if (mem2dcache_ack_o) begin
        n_resp++;
        check("resp_pending", 128'(resp_q.size() > 0), 128'(1));
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          check("resp_data", mem2dcache_data_o, r.data);
          check("resp_cycle", 128'(cyc), 128'(r.cyc));
        end
      end
    end
  endtask

  // expected beats in bus order plus the expected response for one request
  task automatic push_exp(input logic w, input logic [31:0] a, input logic [127:0] d,
                          input logic [127:0] rdata, input int ack_cyc);
    logic [1:0] st;
    logic [1:0] ix;
    beat_t      b;
    resp_t      r;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    st = w ? 2'd0 : a[3:2];
`else
    st = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      ix      = 2'(st + 2'(k));
      b.addr  = {a[31:4], ix, 2'b00};
      b.we    = w;
      b.wdata = d[ix*32 +: 32];
      beat_q.push_back(b);
    end
    if (!w) last_line = rdata;
    r.data = last_line;
    r.cyc  = ack_cyc;
    resp_q.push_back(r);
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [127:0] d);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (n_resp >= target) break;
    end
    check("resp_arrived", 128'(n_resp >= target), 128'(1));
    if (n_resp < target) begin
      beat_q.delete();
      resp_q.delete();
    end
  endtask

  task automatic set_waits(input int w0, input int w1, input int w2, input int w3);
    wait_tab[0] = w0;
    wait_tab[1] = w1;
    wait_tab[2] = w2;
    wait_tab[3] = w3;
  endtask

  initial begin
    int t;
    int n_before;

    tab[0] = '{1'b0, 32'h0000_1234, 128'h0, 32'hA000_0000, 0,
               128'hA0000003_A0000002_A0000001_A0000000, 5};
    tab[1] = '{1'b1, 32'h0000_0080, 128'h44444444_33333333_22222222_11111111, 32'h0, 2,
               128'hA0000003_A0000002_A0000001_A0000000, 13};
    tab[2] = '{1'b0, 32'h0000_2008, 128'h0, 32'hB000_0000, 1,
               128'hB0000003_B0000002_B0000001_B0000000, 9};
    tab[3] = '{1'b1, 32'hFFFF_FFF0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 32'h0, 0,
               128'hB0000003_B0000002_B0000001_B0000000, 5};
    tab[4] = '{1'b0, 32'h0000_000C, 128'h0, 32'hC000_0000, 3,
               128'hC0000003_C0000002_C0000001_C0000000, 17};

    fork
      run_monitor();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_ack",   128'(mem2dcache_ack_o), 128'(0));
    check("rst_data",  mem2dcache_data_o, 128'(0));
    check("rst_req",   128'(mem_req_o), 128'(0));
    check("rst_we",    128'(mem_we_o), 128'(0));
    check("rst_addr",  128'(mem_addr_o), 128'(0));
    check("rst_wdata", 128'(mem_wdata_o), 128'(0));
    check("rst_sel",   128'(mem_sel_byte_o), 128'(4'hF));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single transfers
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      set_waits(tab[i].w, tab[i].w, tab[i].w, tab[i].w);
      rd_base = tab[i].base;
      t = n_resp + 1;
      drive(tab[i].wr, tab[i].addr, tab[i].data);
      push_exp(tab[i].wr, tab[i].addr, tab[i].data, tab[i].exp_data, cyc + tab[i].exp_lat);
      wait_resp(t);
      req = 1'b0;
      repeat (2) @(negedge clk);
    end

    // back-to-back reads with req held through the response
    @(negedge clk);
    #2;
    set_waits(0, 0, 0, 0);
    rd_base = 32'hD000_0000;
    t = n_resp + 1;
    drive(1'b0, 32'h0000_3000, 128'h0);
    push_exp(1'b0, 32'h0000_3000, 128'h0, line_of(32'hD000_0000), cyc + 5);
    wait_resp(t);
    rd_base = 32'hE000_0000;
    addr    = 32'h0000_3014;
    push_exp(1'b0, 32'h0000_3014, 128'h0, line_of(32'hE000_0000), cyc + 1 + 5);
    @(negedge clk);
    #2;
    check("b2b_idle_gap", 128'(mem_req_o), 128'(0));
    @(negedge clk);
    #2;
    check("b2b_restart", 128'(mem_req_o), 128'(1));
    wait_resp(t + 1);
    req = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b_ack_count", 128'(n_resp), 128'(t + 1));

    // 20-cycle stall on beat 0 of a writeback
    @(negedge clk);
    #2;
    set_waits(20, 0, 0, 0);
    t = n_resp + 1;
    drive(1'b1, 32'h0000_0400, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    push_exp(1'b1, 32'h0000_0400, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 128'h0, cyc + 25);
    wait_resp(t);
    req = 1'b0;
    repeat (2) @(negedge clk);

    // reset during beat 2 of a read, then a clean read
    @(negedge clk);
    #2;
    set_waits(0, 0, 0, 0);
    rd_base = 32'hF000_0000;
    n_before = n_resp;
    drive(1'b0, 32'h0000_5000, 128'h0);
    push_exp(1'b0, 32'h0000_5000, 128'h0, line_of(32'hF000_0000), cyc + 5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (mem_req_o && beat_no == 2'd2) break;
    end
    check("rst_mid_in_beat2", 128'(mem_req_o && beat_no == 2'd2), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", 128'(mem_req_o), 128'(0));
    check("rst_mid_no_ack",   128'(mem2dcache_ack_o), 128'(0));
    beat_q.delete();
    resp_q.delete();
    req = 1'b0;
    last_line = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_mid_line_clr", mem2dcache_data_o, 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_ack_count", 128'(n_resp), 128'(n_before));
    #2;
    rd_base = 32'h9000_0000;
    t = n_resp + 1;
    drive(1'b0, 32'h0000_5008, 128'h0);
    push_exp(1'b0, 32'h0000_5008, 128'h0, line_of(32'h9000_0000), cyc + 5);
    wait_resp(t);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("post_hold_data", mem2dcache_data_o, line_of(32'h9000_0000));

    check("beats_drained", 128'(beat_q.size()), 128'(0));
    check("resps_drained", 128'(resp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
